// File: rtl/abs_window_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// abs_window_accumulator_pkg
// Shared definitions for the magnitude window accumulator:
//   - GPIO config word field positions (log2 window length, enable)
//   - controller state encoding
//   - clamp helper for the requested log2 window length
// ----------------------------------------------------------------------------
package abs_window_accumulator_pkg;

   localparam int LOG2_LEN_LSB = 0;
   localparam int LOG2_LEN_W   = 5;
   localparam int ENABLE_BIT   = 31;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   // Requested lengths beyond what the accumulator is sized for fall back to
   // the largest supported window.
   function automatic logic [LOG2_LEN_W-1:0] clamp_log2(
      input logic [LOG2_LEN_W-1:0] req,
      input logic [LOG2_LEN_W-1:0] lim
   );
      return (req > lim) ? lim : req;
   endfunction

endpackage

// File: rtl/abs_window_accumulator_window_counter.sv
// ----------------------------------------------------------------------------
// abs_window_accumulator_window_counter
// Loadable sample counter for one accumulation window.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   load_i  : clear the count and latch len_i as the window's log2 length
//   len_i   : log2 window length (already clamped to max_log2)
//   inc_i   : a sample is accepted this cycle
//   last_o  : the sample accepted this cycle completes the window
//   len_o   : log2 length latched for the current window
// ----------------------------------------------------------------------------
module abs_window_accumulator_window_counter
   import abs_window_accumulator_pkg::*;
#(
   parameter int max_log2 = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [LOG2_LEN_W-1:0] len_i,
   input  logic                  inc_i,
   output logic                  last_o,
   output logic [LOG2_LEN_W-1:0] len_o
);

   localparam logic [max_log2:0] ONE = (max_log2+1)'(1);

   logic [max_log2-1:0]   cnt_q;
   logic [LOG2_LEN_W-1:0] len_q;
   logic [max_log2:0]     last_idx;

   // Index of the final sample: 2^len - 1, one bit wider so len=max_log2 fits.
   assign last_idx = (ONE << len_q) - ONE;
   assign last_o   = inc_i && ({1'b0, cnt_q} == last_idx);
   assign len_o    = len_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
         len_q <= len_i;
      end else if (inc_i) begin
         cnt_q <= cnt_q + max_log2'(1);
      end
   end

endmodule

// File: rtl/abs_window_accumulator.sv
// ----------------------------------------------------------------------------
// abs_window_accumulator
// Integrates the unsigned magnitude stream over a power-of-two window of
// accepted samples and reports sum, floor mean and peak once per window.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   gpio0_i : config word, [4:0] log2 window length, [31] enable
//   data_i  : unsigned magnitude sample
//   valid_i : data_i qualifier
//   sum_o   : sum of the last completed window
//   mean_o  : sum_o >> log2 length of that window
//   peak_o  : largest sample of that window
//   valid_o : one-cycle pulse when sum_o/mean_o/peak_o update
//   busy_o  : high while accumulating a window
// ----------------------------------------------------------------------------
module abs_window_accumulator
   import abs_window_accumulator_pkg::*;
#(
   parameter int data_width = 16,
   parameter int max_log2   = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [31:0]                    gpio0_i,
   input  logic [data_width-1:0]          data_i,
   input  logic                           valid_i,
   output logic [data_width+max_log2-1:0] sum_o,
   output logic [data_width-1:0]          mean_o,
   output logic [data_width-1:0]          peak_o,
   output logic                           valid_o,
   output logic                           busy_o
);

   localparam int SUM_W = data_width + max_log2;
   localparam logic [LOG2_LEN_W-1:0] MAX_L = LOG2_LEN_W'(max_log2);

   function automatic logic [data_width-1:0] max_u(
      input logic [data_width-1:0] a,
      input logic [data_width-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   // Floor mean; the quotient of a full window always fits in data_width bits.
   function automatic logic [data_width-1:0] mean_of(
      input logic [SUM_W-1:0]      sum,
      input logic [LOG2_LEN_W-1:0] len
   );
      logic [SUM_W-1:0] shifted;
      shifted = sum >> len;
      return shifted[data_width-1:0];
   endfunction

   state_t                state_q;
   logic [SUM_W-1:0]      acc_q;
   logic [data_width-1:0] peak_q;

   logic                  enable;
   logic [LOG2_LEN_W-1:0] len_cfg;
   logic [LOG2_LEN_W-1:0] len_win;
   logic                  accept;
   logic                  last;
   logic                  cnt_load;
   logic [SUM_W-1:0]      acc_next;
   logic [data_width-1:0] peak_next;
   logic                  unused_gpio;

   assign enable      = gpio0_i[ENABLE_BIT];
   assign len_cfg     = clamp_log2(gpio0_i[LOG2_LEN_LSB +: LOG2_LEN_W], MAX_L);
   assign unused_gpio = ^gpio0_i[ENABLE_BIT-1:LOG2_LEN_LSB+LOG2_LEN_W];

   assign accept    = (state_q == ST_ACCUM) && valid_i;
   assign acc_next  = acc_q + SUM_W'(data_i);
   assign peak_next = max_u(peak_q, data_i);

   // The length is (re)latched every IDLE cycle, so the value present on the
   // IDLE->ACCUM edge sticks; a window end reloads it for a back-to-back window.
   assign cnt_load = (state_q == ST_IDLE) || last;

   abs_window_accumulator_window_counter #(
      .max_log2 (max_log2)
   ) u_window_counter (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (cnt_load),
      .len_i  (len_cfg),
      .inc_i  (accept),
      .last_o (last),
      .len_o  (len_win)
   );

   assign busy_o = (state_q == ST_ACCUM);

   // Accumulate stage -> registered window result
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         peak_q  <= '0;
         sum_o   <= '0;
         mean_o  <= '0;
         peak_o  <= '0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               acc_q  <= '0;
               peak_q <= '0;
               if (enable) state_q <= ST_ACCUM;
            end
            ST_ACCUM: begin
               // A completing sample is emitted even if enable drops with it.
               if (last) begin
                  sum_o   <= acc_next;
                  mean_o  <= mean_of(acc_next, len_win);
                  peak_o  <= peak_next;
                  valid_o <= 1'b1;
                  acc_q   <= '0;
                  peak_q  <= '0;
                  if (!enable) state_q <= ST_IDLE;
               end else if (!enable) begin
                  acc_q   <= '0;
                  peak_q  <= '0;
                  state_q <= ST_IDLE;
               end else if (accept) begin
                  acc_q  <= acc_next;
                  peak_q <= peak_next;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_abs_window_accumulator.sv
module tb_abs_window_accumulator;

   localparam int DW = 16;
   localparam int ML = 16;
   localparam int SW = DW + ML;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   gpio;
   logic [DW-1:0] data;
   logic          vld;
   logic [SW-1:0] sum_o;
   logic [DW-1:0] mean_o;
   logic [DW-1:0] peak_o;
   logic          valid_o;
   logic          busy_o;

   abs_window_accumulator #(
      .data_width (DW),
      .max_log2   (ML)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .gpio0_i (gpio),
      .data_i  (data),
      .valid_i (vld),
      .sum_o   (sum_o),
      .mean_o  (mean_o),
      .peak_o  (peak_o),
      .valid_o (valid_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint unsigned sum;
      longint unsigned mean;
      longint unsigned peak;
   } exp_t;

   exp_t            exp_q[$];
   int              n_cmp = 0;
   int              n_bad = 0;
   longint unsigned held_sum = 0, held_mean = 0, held_peak = 0;

   // Reference model: a window is simply the list of accepted samples.
   bit              m_active = 1'b0;
   int              m_len = 0;
   longint unsigned m_win[$];

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endfunction

   function automatic void emit_window();
      exp_t e;
      e.sum  = 0;
      e.peak = 0;
      foreach (m_win[i]) begin
         e.sum += m_win[i];
         if (m_win[i] > e.peak) e.peak = m_win[i];
      end
      e.mean = e.sum / (64'd1 << m_len);
      exp_q.push_back(e);
   endfunction

   function automatic void model_step(bit en, int len_field, bit v, longint unsigned d);
      int eff;
      eff = (len_field > ML) ? ML : len_field;
      if (!m_active) begin
         m_win.delete();
         m_len    = eff;
         m_active = en;
      end else if (v && (m_win.size() == (1 << m_len) - 1)) begin
         m_win.push_back(d);
         emit_window();
         m_win.delete();
         if (en) m_len = eff;
         else    m_active = 1'b0;
      end else if (!en) begin
         m_active = 1'b0;
         m_win.delete();
      end else if (v) begin
         m_win.push_back(d);
      end
   endfunction

   task automatic drive(bit en, int len_field, bit v, logic [DW-1:0] d);
      gpio = {en, 26'($urandom), 5'(len_field)};
      data = d;
      vld  = v;
      if (rst_n) model_step(en, len_field, v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 31), $urandom_range(0, 1), 16'($urandom));
   endtask

   task automatic check_hold(string name);
      check({name, "_sum"},  sum_o,  held_sum);
      check({name, "_mean"}, mean_o, held_mean);
      check({name, "_peak"}, peak_o, held_peak);
      check({name, "_busy"}, busy_o, m_active);
   endtask

   // Monitor: every valid_o pulse must match the oldest expected window.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && valid_o !== 1'b0) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_valid: got valid_o=%b sum=0x%0h, expected no pulse", valid_o, sum_o);
            end else begin
               e = exp_q.pop_front();
               check("win_sum",  sum_o,  e.sum);
               check("win_mean", mean_o, e.mean);
               check("win_peak", peak_o, e.peak);
               held_sum  = e.sum;
               held_mean = e.mean;
               held_peak = e.peak;
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      gpio  = '0;
      data  = '0;
      vld   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sum",   sum_o,   0);
      check("rst_mean",  mean_o,  0);
      check("rst_peak",  peak_o,  0);
      check("rst_valid", valid_o, 0);
      check("rst_busy",  busy_o,  0);
      rst_n = 1'b1;

      // Disabled: samples are dropped, no pulses.
      idle(20);
      check_hold("disabled");

      // Basic window of 4.
      drive(1'b1, 2, 1'b0, 0);
      drive(1'b1, 2, 1'b1, 3);
      drive(1'b1, 2, 1'b1, 5);
      drive(1'b1, 2, 1'b1, 7);
      check("basic_early_valid", valid_o, 0);
      drive(1'b1, 2, 1'b1, 9);
      check("basic_valid", valid_o, 1);
      check("basic_sum", sum_o, 24);
      drive(1'b0, 2, 1'b0, 0);
      check("basic_one_cycle", valid_o, 0);
      idle(3);
      check_hold("basic_hold");

      // Gap inside a window, then back-to-back window.
      drive(1'b1, 1, 1'b0, 0);
      drive(1'b1, 1, 1'b1, 10);
      drive(1'b1, 1, 1'b0, 0);
      drive(1'b1, 1, 1'b1, 20);
      check("gap_valid", valid_o, 1);
      drive(1'b1, 1, 1'b1, 1);
      check("b2b_busy", busy_o, 1);
      drive(1'b1, 1, 1'b1, 1);
      check("b2b_valid", valid_o, 1);
      check("b2b_sum", sum_o, 2);
      idle(3);
      check_hold("b2b_hold");

      // Abort after 5 of 8 samples, then a full window of max values.
      drive(1'b1, 3, 1'b0, 0);
      for (int i = 0; i < 5; i++) drive(1'b1, 3, 1'b1, 16'($urandom));
      drive(1'b0, 3, 1'b0, 0);
      idle(4);
      check_hold("abort_hold");
      drive(1'b1, 3, 1'b0, 0);
      for (int i = 0; i < 8; i++) drive(1'b1, 3, 1'b1, 16'hFFFF);
      idle(3);
      check("abort_refill_sum", sum_o, 64'h7FFF8);
      check("abort_refill_mean", mean_o, 64'hFFFF);

      // Length rewritten mid-window: applies only from the next window.
      drive(1'b1, 1, 1'b0, 0);
      drive(1'b1, 1, 1'b1, 16'($urandom));
      drive(1'b1, 3, 1'b1, 16'($urandom));
      for (int i = 0; i < 8; i++) drive(1'b1, 0, 1'b1, 16'($urandom));
      check("cfg_change_valid", valid_o, 1);
      idle(3);

      // Window of one sample: every sample pulses.
      drive(1'b1, 0, 1'b0, 0);
      for (int i = 0; i < 6; i++) drive(1'b1, 0, 1'b1, 16'($urandom));
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++)
         drive($urandom_range(0, 99) < 97, $urandom_range(0, 4), $urandom_range(0, 9) < 7, 16'($urandom));
      idle(4);
      check_hold("random_hold");

      // Asynchronous reset in the middle of a window.
      drive(1'b1, 2, 1'b0, 0);
      drive(1'b1, 2, 1'b1, 100);
      drive(1'b1, 2, 1'b1, 200);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_sum",   sum_o,   0);
      check("arst_mean",  mean_o,  0);
      check("arst_peak",  peak_o,  0);
      check("arst_valid", valid_o, 0);
      check("arst_busy",  busy_o,  0);
      m_active = 1'b0;
      m_win.delete();
      exp_q.delete();
      held_sum  = 0;
      held_mean = 0;
      held_peak = 0;
      drive(1'b1, 2, 1'b1, 300);
      rst_n = 1'b1;
      idle(5);
      check_hold("arst_after");

      // Clamped length: 31 behaves as 16, full-scale samples.
      drive(1'b1, 31, 1'b0, 0);
      for (int i = 0; i < 65536; i++) begin
         drive(1'b1, 31, 1'b1, 16'hFFFF);
         if (i == 40000) check("clamp_busy", busy_o, 1);
      end
      check("clamp_valid", valid_o, 1);
      check("clamp_sum", sum_o, 64'hFFFF0000);
      check("clamp_mean", mean_o, 64'hFFFF);
      idle(4);
      check_hold("clamp_hold");

      check("pending_windows", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
